// File: rtl/ysyx_22050019_mem_arbiter_pkg.sv
// Shared encodings and default widths for the memory arbiter and its IFU/LSU clients.
package ysyx_22050019_mem_arbiter_pkg;

    localparam int unsigned DEF_ADDR_W = 32;
    localparam int unsigned DEF_DATA_W = 64;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait
    } state_e;

    typedef enum logic [1:0] {
        OwnNone,
        OwnIfu,
        OwnLsu
    } owner_e;

endpackage

// File: rtl/ysyx_22050019_mem_arbiter.sv
// Single-outstanding arbiter sharing one memory port between IFU fetches and LSU accesses.
// LSU has strict priority; an IFU flush drops the in-flight fetch response.
module ysyx_22050019_mem_arbiter
    import ysyx_22050019_mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_addr,
    input  logic                ifu_flush,
    output logic                ifu_rsp_valid,
    output logic [DATA_W-1:0]   ifu_rdata,

    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic                lsu_wen,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wstrb,
    output logic                lsu_rsp_valid,
    output logic [DATA_W-1:0]   lsu_rdata,

    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wen,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic                mem_rsp_valid,
    input  logic [DATA_W-1:0]   mem_rdata,

    output logic                ifu_stall_req,
    output logic                lsu_stall_req
);

    state_e                state_q, state_d;
    owner_e                owner_q, owner_d;
    logic                  drop_q, drop_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic                  wen_q, wen_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [DATA_W/8-1:0]   wstrb_q, wstrb_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            owner_q <= OwnNone;
            drop_q  <= 1'b0;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            drop_q  <= drop_d;
            addr_q  <= addr_d;
            wen_q   <= wen_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        drop_d        = drop_q;
        addr_d        = addr_q;
        wen_d         = wen_q;
        wdata_d       = wdata_q;
        wstrb_d       = wstrb_q;
        ifu_req_ready = 1'b0;
        lsu_req_ready = 1'b0;
        ifu_rsp_valid = 1'b0;
        lsu_rsp_valid = 1'b0;
        mem_req_valid = 1'b0;

        case (state_q)
            StIdle: begin
                if (lsu_req_valid) begin
                    lsu_req_ready = 1'b1;
                    addr_d        = lsu_addr;
                    wen_d         = lsu_wen;
                    wdata_d       = lsu_wdata;
                    wstrb_d       = lsu_wstrb;
                    owner_d       = OwnLsu;
                    state_d       = StIssue;
                end else if (ifu_req_valid && !ifu_flush) begin
                    ifu_req_ready = 1'b1;
                    addr_d        = ifu_addr;
                    wen_d         = 1'b0;
                    wstrb_d       = '0;
                    owner_d       = OwnIfu;
                    state_d       = StIssue;
                end
            end
            StIssue: begin
                mem_req_valid = 1'b1;
                if (ifu_flush && owner_q == OwnIfu) drop_d = 1'b1;
                if (mem_req_ready) state_d = StWait;
            end
            StWait: begin
                if (ifu_flush && owner_q == OwnIfu) drop_d = 1'b1;
                if (mem_rsp_valid) begin
                    // A flush arriving with the response still kills it.
                    lsu_rsp_valid = (owner_q == OwnLsu);
                    ifu_rsp_valid = (owner_q == OwnIfu) && !drop_q && !ifu_flush;
                    owner_d       = OwnNone;
                    drop_d        = 1'b0;
                    state_d       = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                owner_d = OwnNone;
                drop_d  = 1'b0;
            end
        endcase

        if (!rst_n) begin
            ifu_req_ready = 1'b0;
            lsu_req_ready = 1'b0;
            ifu_rsp_valid = 1'b0;
            lsu_rsp_valid = 1'b0;
            mem_req_valid = 1'b0;
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wen   = wen_q;
    assign mem_wdata = wdata_q;
    assign mem_wstrb = wstrb_q;
    assign ifu_rdata = mem_rdata;
    assign lsu_rdata = mem_rdata;

    assign lsu_stall_req = (lsu_req_valid | (owner_q == OwnLsu)) & ~lsu_rsp_valid;
    assign ifu_stall_req = (ifu_req_valid | ((owner_q == OwnIfu) & ~drop_q)) & ~ifu_rsp_valid;

endmodule
